alu_muldiv_seq: RTL and testbench

//  Iterative multiply/divide unit, the parametrised sequential companion to the single-cycle ALU.

---
 rtl/muldiv_pkg.sv | 38 +++
 rtl/alu_muldiv_seq.sv | 191 +++++++++++++++++++
 tb/tb_alu_muldiv_seq.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and op-decoding helpers for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    MDU_MUL    = 3'd0,
    MDU_MULH   = 3'd1,
    MDU_MULHSU = 3'd2,
    MDU_MULHU  = 3'd3,
    MDU_DIV    = 3'd4,
    MDU_DIVU   = 3'd5,
    MDU_REM    = 3'd6,
    MDU_REMU   = 3'd7
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } mdu_state_t;

  function automatic logic is_signed_a(input mdu_op_t op);
    return (op == MDU_MUL) || (op == MDU_MULH) || (op == MDU_MULHSU) ||
           (op == MDU_DIV) || (op == MDU_REM);
  endfunction

  function automatic logic is_signed_b(input mdu_op_t op);
    return (op == MDU_MUL) || (op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM);
  endfunction

  function automatic logic is_div_op(input mdu_op_t op);
    return op[2];
  endfunction

  function automatic logic is_rem_op(input mdu_op_t op);
    return op[2] & op[1];
  endfunction

endpackage

// File: rtl/alu_muldiv_seq.sv
// Iterative RV32M multiply/divide unit: magnitudes are processed one bit per cycle,
// then the sign is applied once at the end.
module alu_muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] inputA,
  input  logic [WIDTH-1:0] inputB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             negative,
  output logic             zero,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);
  localparam logic [WIDTH-1:0] MIN_INT  = {1'b1, {(WIDTH-1){1'b0}}};

  mdu_state_t         state_q, state_d;
  mdu_op_t            op_q, op_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               out_valid_q, out_valid_d;
  logic               negative_q, negative_d;
  logic               zero_q, zero_d;

  mdu_op_t            op_in;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic               div_zero, div_ovf, special;
  logic [WIDTH-1:0]   special_res;

  assign op_in = mdu_op_t'(op);

  // Request decode: operand magnitudes, and the RISC-V cases that need no iteration.
  always_comb begin
    a_neg       = is_signed_a(op_in) & inputA[WIDTH-1];
    b_neg       = is_signed_b(op_in) & inputB[WIDTH-1];
    abs_a       = a_neg ? -inputA : inputA;
    abs_b       = b_neg ? -inputB : inputB;
    div_zero    = is_div_op(op_in) && (inputB == '0);
    div_ovf     = ((op_in == MDU_DIV) || (op_in == MDU_REM)) &&
                  (inputA == MIN_INT) && (inputB == '1);
    special     = div_zero | div_ovf;
    special_res = '0;
    if (div_zero) begin
      special_res = is_rem_op(op_in) ? inputA : '1;
    end else if (div_ovf) begin
      special_res = is_rem_op(op_in) ? '0 : MIN_INT;
    end
  end

  logic [WIDTH:0]     mul_sum, rem_sh, div_diff;
  logic [2*WIDTH-1:0] step_acc, prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix, fin_res;

  // acc holds {partial product, multiplier} for mul and {remainder, quotient} for div.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff = rem_sh - {1'b0, opb_q};
    if (!is_div_op(op_q)) begin
      step_acc = {mul_sum, acc_q[WIDTH-1:1]};
    end else if (div_diff[WIDTH]) begin
      step_acc = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end else begin
      step_acc = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end

    prod_fix = neg_q ? -acc_q : acc_q;
    quot_fix = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    case (op_q)
      MDU_MUL:                        fin_res = prod_fix[WIDTH-1:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU: fin_res = prod_fix[2*WIDTH-1:WIDTH];
      MDU_DIV, MDU_DIVU:              fin_res = quot_fix;
      default:                        fin_res = rem_fix;
    endcase
  end

  // Special results enter DONE without out_valid; it rises on the following edge,
  // so out_ready is only honoured once the result is actually presented.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    acc_d       = acc_q;
    opb_d       = opb_q;
    cnt_d       = cnt_q;
    neg_d       = neg_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
    negative_d  = negative_q;
    zero_d      = zero_q;

    case (state_q)
      IDLE: begin
        if (in_valid && !flush) begin
          op_d  = op_in;
          opb_d = abs_b;
          neg_d = is_rem_op(op_in) ? a_neg : (a_neg ^ b_neg);
          cnt_d = '0;
          if (special) begin
            result_d = special_res;
            state_d  = DONE;
          end else begin
            acc_d   = {{WIDTH{1'b0}}, abs_a};
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (cnt_q != CNT_LAST) begin
          acc_d = step_acc;
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          result_d    = fin_res;
          out_valid_d = 1'b1;
          negative_d  = fin_res[WIDTH-1];
          zero_d      = (fin_res == '0);
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          negative_d  = 1'b0;
          zero_d      = 1'b0;
          state_d     = IDLE;
        end else begin
          out_valid_d = 1'b1;
          negative_d  = result_q[WIDTH-1];
          zero_d      = (result_q == '0);
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      negative_d  = 1'b0;
      zero_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= MDU_MUL;
      acc_q       <= '0;
      opb_q       <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      negative_q  <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      acc_q       <= acc_d;
      opb_q       <= opb_d;
      cnt_q       <= cnt_d;
      neg_q       <= neg_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      negative_q  <= negative_d;
      zero_q      <= zero_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && !flush;
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign negative  = negative_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Scoreboard bench for alu_muldiv_seq: issued requests push the reference-model result,
// a negedge monitor pops and compares whenever a result is handed over.
module tb_alu_muldiv_seq;

  localparam int WIDTH = 32;
  localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3;
  localparam logic [2:0] OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;

  logic             clk = 1'b0;
  logic             rst, flush, in_valid, out_ready;
  logic             in_ready, out_valid, negative, zero, busy;
  logic [2:0]       op;
  logic [WIDTH-1:0] inputA, inputB, result;

  int passCount  = 0;
  int checkCount = 0;
  int popCount   = 0;
  int issueCount = 0;
  logic [31:0] expQ[$];
  logic [31:0] monExp;

  always #5 clk = ~clk;

  alu_muldiv_seq #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .inputA(inputA), .inputB(inputB), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .negative(negative), .zero(zero), .busy(busy)
  );

  // Reference model: plain 64-bit / native signed arithmetic with the RISC-V corner rules.
  function automatic logic [31:0] refModel(input logic [2:0] o, input logic [31:0] a,
                                           input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    int ia, ib;
    logic ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'(a);
    ub  = longint'(b);
    ia  = int'(a);
    ib  = int'(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (o)
      OP_MUL:    begin p = 64'(sa * sb); return p[31:0];  end
      OP_MULH:   begin p = 64'(sa * sb); return p[63:32]; end
      OP_MULHSU: begin p = 64'(sa * ub); return p[63:32]; end
      OP_MULHU:  begin p = 64'(ua * ub); return p[63:32]; end
      OP_DIV:    return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(ia / ib));
      OP_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REM:    return (b == 0) ? a : (ovf ? 32'd0 : 32'(ia % ib));
      default:   return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  task automatic timeoutFail(input string name);
    checkCount++;
    $display("[TB] FAIL %s: timed out waiting for the DUT", name);
  endtask

  // Monitor: one pop per result handed over (out_valid && out_ready at the next edge).
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (expQ.size() == 0) begin
        checkCount++;
        $display("[TB] FAIL unexpected_result: got 0x%08h, expected no result", result);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("result", result, monExp);
        checkOutput("negative", {31'd0, negative}, {31'd0, monExp[31]});
        checkOutput("zero", {31'd0, zero}, {31'd0, monExp == 32'd0});
      end
      popCount++;
    end
  end

  // Returns #1 after the accept edge; operands are scrambled afterwards on purpose.
  task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a,
                               input logic [31:0] b, input bit push);
    int guard = 0;
    while (!in_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) timeoutFail("in_ready");
    op = o; inputA = a; inputB = b; in_valid = 1'b1;
    if (push) begin
      expQ.push_back(refModel(o, a, b));
      issueCount++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    op       = 3'($urandom_range(0, 7));
    inputA   = $urandom;
    inputB   = $urandom;
  endtask

  task automatic waitResult(input bit randReady);
    int guard = 0;
    while (popCount < issueCount && guard < 400) begin
      if (randReady) out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      guard++;
    end
    out_ready = 1'b1;
    if (popCount < issueCount) timeoutFail("wait_result");
  endtask

  task automatic issueTimed(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                            input int expLat, input string name);
    int n = 0;
    bit readyLow = 1'b1;
    applyStimulus(o, a, b, 1'b1);
    while (!out_valid && n < 100) begin
      if (in_ready) readyLow = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    checkOutput({name, "_latency"}, 32'(n), 32'(expLat));
    checkOutput({name, "_in_ready_low"}, {31'd0, readyLow}, 32'd1);
    waitResult(1'b0);
  endtask

  initial begin
    logic [31:0] r, a, b;
    logic [2:0]  o;
    logic        n, z;
    bit          stable, sawValid;
    int          sel, guard;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = 3'd0; inputA = '0; inputB = '0;
    #3;
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_result", result, 32'd0);
    checkOutput("rst_negative", {31'd0, negative}, 32'd0);
    checkOutput("rst_zero", {31'd0, zero}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    issueTimed(OP_MUL, 32'd7, 32'hFFFF_FFFD, WIDTH + 1, "mul_7x-3");

    applyStimulus(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1); waitResult(1'b0);
    applyStimulus(OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1); waitResult(1'b0);
    applyStimulus(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1); waitResult(1'b0);
    applyStimulus(OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1); waitResult(1'b0);
    applyStimulus(OP_DIV,    32'hFFFF_FFF9, 32'd2, 1'b1);         waitResult(1'b0);
    applyStimulus(OP_REM,    32'hFFFF_FFF9, 32'd2, 1'b1);         waitResult(1'b0);
    applyStimulus(OP_DIVU,   32'd100, 32'd7, 1'b1);               waitResult(1'b0);
    applyStimulus(OP_REMU,   32'd100, 32'd7, 1'b1);               waitResult(1'b0);

    issueTimed(OP_DIV,  32'd5, 32'd0, 1, "div_by_zero");
    issueTimed(OP_REMU, 32'd5, 32'd0, 1, "remu_by_zero");
    issueTimed(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1, "div_overflow");
    issueTimed(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 1, "rem_overflow");

    // Backpressure: result and flags must hold while out_ready stays low.
    out_ready = 1'b0;
    applyStimulus(OP_MULH, 32'h8765_4321, 32'h1234_5678, 1'b1);
    guard = 0;
    while (!out_valid && guard < 100) begin @(posedge clk); #1; guard++; end
    if (!out_valid) timeoutFail("backpressure_valid");
    r = result; n = negative; z = zero;
    stable = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (!out_valid || result !== r || negative !== n || zero !== z) stable = 1'b0;
    end
    checkOutput("backpressure_stable", {31'd0, stable}, 32'd1);
    out_ready = 1'b1;
    waitResult(1'b0);

    // Flush in the middle of a multiply: nothing may come out.
    applyStimulus(OP_MUL, 32'd123, 32'd456, 1'b0);
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    #1 checkOutput("flush_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    checkOutput("flush_busy", {31'd0, busy}, 32'd0);
    checkOutput("flush_out_valid", {31'd0, out_valid}, 32'd0);
    sawValid = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) sawValid = 1'b1; end
    checkOutput("flush_no_result", {31'd0, sawValid}, 32'd0);

    in_valid = 1'b1; op = OP_MUL; inputA = 32'd3; inputB = 32'd3; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    checkOutput("flush_blocks_accept", {31'd0, busy}, 32'd0);
    applyStimulus(OP_MUL, 32'd6, 32'd7, 1'b1); waitResult(1'b0);

    // Asynchronous reset pulse between edges while calculating.
    applyStimulus(OP_DIVU, 32'd1000, 32'd7, 1'b0);
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("async_rst_busy", {31'd0, busy}, 32'd0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("after_rst_out_valid", {31'd0, out_valid}, 32'd0);
    applyStimulus(OP_DIVU, 32'd9, 32'd3, 1'b1); waitResult(1'b0);

    // Randomized ops with corner operands mixed in and random backpressure.
    for (int i = 0; i < 40; i++) begin
      o   = 3'($urandom_range(0, 7));
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) b = 32'd0;
      if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      if (sel == 2) b = 32'($urandom_range(1, 15));
      applyStimulus(o, a, b, 1'b1);
      waitResult(1'b1);
    end

    if (expQ.size() != 0) timeoutFail("scoreboard_drain");
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
